// File: rtl/phrase_packer.sv
// Packs a stream of pixel words into multi-word phrases for the DRAM write path.
// Optionally flushes a partial phrase so every phrase can start at a frame start.
module phrase_packer #(
   parameter int                WORD_W      = 16,
   parameter int                WORDS       = 8,
   parameter bit                ALIGN_FRAME = 1'b1,
   parameter logic [WORD_W-1:0] PAD_WORD    = '0
) (
   input  logic                         clk_in,
   input  logic                         rst_in,
   input  logic                         valid_in,
   output logic                         ready_in,
   input  logic [WORD_W-1:0]            data_in,
   input  logic                         newframe_in,
   output logic                         valid_out,
   input  logic                         ready_out,
   output logic [WORD_W*WORDS-1:0]      data_out,
   output logic                         tuser_out,
   output logic [$clog2(WORDS+1)-1:0]   count_out
);

   localparam int PHRASE_W = WORD_W * WORDS;
   localparam int CNT_W    = $clog2(WORDS + 1);
   localparam int OFF_W    = $clog2(WORDS);
   localparam logic [OFF_W-1:0] LAST = OFF_W'(WORDS - 1);

   typedef enum logic {FILL, HOLD} state_t;

   state_t state;
   state_t state_d;

   logic [WORD_W-1:0] acc [WORDS];
   logic [OFF_W-1:0]  offset;
   logic              acc_tuser;

   logic out_free;
   logic flush_need;
   logic take;
   logic do_flush;
   logic do_complete;
   logic drain;
   logic load;
   logic tuser_next;

   logic [PHRASE_W-1:0] phrase;
   logic                phrase_tuser;
   logic [CNT_W-1:0]    phrase_count;
   logic [WORD_W-1:0]   word;

   always_comb begin
      out_free   = !valid_out || ready_out;
      flush_need = ALIGN_FRAME && newframe_in && (offset != '0);
      ready_in   = 1'b0;
      state_d    = state;
      unique case (state)
         FILL:    ready_in = !(flush_need && !out_free);
         HOLD:    ready_in = 1'b0;
         default: ready_in = 1'b0;
      endcase
      take        = valid_in && ready_in;
      do_flush    = take && flush_need;
      do_complete = take && !flush_need && (offset == LAST);
      drain       = (state == HOLD) && out_free;
      load        = do_flush || (do_complete && out_free) || drain;
      // ALIGN_FRAME=0 folds every newframe into the phrase flag
      tuser_next  = (offset == '0) ? newframe_in
                  : (acc_tuser || (!ALIGN_FRAME && newframe_in));
      if (do_complete && !out_free)
         state_d = HOLD;
      else if (drain)
         state_d = FILL;
   end

   always_comb begin
      phrase       = '0;
      word         = '0;
      phrase_tuser = acc_tuser;
      phrase_count = CNT_W'(WORDS);
      for (int i = 0; i < WORDS; i++) begin
         word = acc[i];
         if (do_complete && i == WORDS - 1)
            word = data_in;
         if (do_flush && OFF_W'(i) >= offset)
            word = PAD_WORD;
         phrase[(WORDS-1-i)*WORD_W +: WORD_W] = word;
      end
      unique case (1'b1)
         do_flush:    phrase_count = CNT_W'(offset);
         do_complete: phrase_tuser = tuser_next;
         default:     ;
      endcase
   end

   always_ff @(posedge clk_in) begin
      if (rst_in)
         state <= FILL;
      else
         state <= state_d;
   end

   always_ff @(posedge clk_in) begin
      if (rst_in) begin
         offset    <= '0;
         acc_tuser <= 1'b0;
         valid_out <= 1'b0;
         data_out  <= '0;
         tuser_out <= 1'b0;
         count_out <= '0;
         for (int i = 0; i < WORDS; i++)
            acc[i] <= '0;
      end else begin
         if (load) begin
            valid_out <= 1'b1;
            data_out  <= phrase;
            tuser_out <= phrase_tuser;
            count_out <= phrase_count;
         end else if (ready_out) begin
            valid_out <= 1'b0;
         end
         // the frame-start word opens a fresh phrase in slot 0
         if (do_flush) begin
            acc[0]    <= data_in;
            acc_tuser <= 1'b1;
            offset    <= OFF_W'(1);
         end else if (take) begin
            acc[offset] <= data_in;
            acc_tuser   <= tuser_next;
            offset      <= (offset == LAST) ? '0 : offset + 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_phrase_packer.sv
// Directed bench for phrase_packer: streaming, backpressure, flush,
// unaligned newframe and mid-phrase reset.
module tb_phrase_packer;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic         rst;
   logic         valid_in;
   logic [15:0]  data_in;
   logic         newframe;
   logic         ready_out;

   logic         ready_in;
   logic         valid_out;
   logic [127:0] data_out;
   logic         tuser_out;
   logic [3:0]   count_out;

   logic         ready0;
   logic         valid0;
   logic [127:0] data0;
   logic         tuser0;
   logic [3:0]   count0;

   int tests = 0;
   int fails = 0;

   typedef struct packed {
      logic [127:0] d;
      logic         t;
      logic [3:0]   c;
   } rec_t;

   rec_t q[$];
   rec_t q0[$];

   phrase_packer dut (
      .clk_in      (clk),
      .rst_in      (rst),
      .valid_in    (valid_in),
      .ready_in    (ready_in),
      .data_in     (data_in),
      .newframe_in (newframe),
      .valid_out   (valid_out),
      .ready_out   (ready_out),
      .data_out    (data_out),
      .tuser_out   (tuser_out),
      .count_out   (count_out)
   );

   phrase_packer #(.ALIGN_FRAME(1'b0)) dut0 (
      .clk_in      (clk),
      .rst_in      (rst),
      .valid_in    (valid_in),
      .ready_in    (ready0),
      .data_in     (data_in),
      .newframe_in (newframe),
      .valid_out   (valid0),
      .ready_out   (ready_out),
      .data_out    (data0),
      .tuser_out   (tuser0),
      .count_out   (count0)
   );

   // phrase capture, sampled mid-cycle
   always @(negedge clk) begin
      if (!rst && valid_out && ready_out)
         q.push_back(rec_t'({data_out, tuser_out, count_out}));
      if (!rst && valid0 && ready_out)
         q0.push_back(rec_t'({data0, tuser0, count0}));
   end

   function automatic logic [127:0] mk(input logic [15:0] b);
      logic [127:0] p = '0;
      for (int i = 0; i < 8; i++)
         p = {p[111:0], 16'(b + 16'(i))};
      return p;
   endfunction

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      valid_in = 1'b0;
      newframe = 1'b0;
      tick(2);
      rst = 1'b0;
   endtask

   // offers one word until accepted; stalls=64 means it never was
   task automatic push(input logic [15:0] d, input logic nf,
                       output int stalls);
      logic r;
      stalls = 0;
      valid_in = 1'b1;
      data_in = d;
      newframe = nf;
      for (int k = 0; k < 64; k++) begin
         @(negedge clk);
         r = ready_in;
         @(posedge clk);
         #1;
         if (r) break;
         stalls++;
      end
      valid_in = 1'b0;
      newframe = 1'b0;
   endtask

   task automatic test_reset();
      ready_out = 1'b1;
      data_in = '0;
      do_reset();
      tests++;
      if (valid_out !== 1'b0) begin
         fails++;
         $display("FAIL rst_valid got %b want 0", valid_out);
      end
      tests++;
      if (tuser_out !== 1'b0) begin
         fails++;
         $display("FAIL rst_tuser got %b want 0", tuser_out);
      end
      tests++;
      if (count_out !== 4'd0) begin
         fails++;
         $display("FAIL rst_count got %0d want 0", count_out);
      end
      tests++;
      if (data_out !== 128'd0) begin
         fails++;
         $display("FAIL rst_data got %h want 0", data_out);
      end
      tests++;
      if (ready_in !== 1'b1) begin
         fails++;
         $display("FAIL rst_ready got %b want 1", ready_in);
      end
   endtask

   task automatic test_stream();
      int st;
      int tot = 0;
      logic ev;
      rec_t got;
      rec_t exp;
      q.delete();
      ready_out = 1'b1;
      for (int n = 1; n <= 32; n++) begin
         push(16'(n), 1'b0, st);
         tot += st;
         ev = (n % 8 == 0);
         tests++;
         if (valid_out !== ev) begin
            fails++;
            $display("FAIL stream_lat w%0d got %b want %b", n, valid_out, ev);
         end
      end
      tick(1);
      tests++;
      if (tot !== 0) begin
         fails++;
         $display("FAIL stream_stalls got %0d want 0", tot);
      end
      tests++;
      if (q.size() !== 4) begin
         fails++;
         $display("FAIL stream_n got %0d want 4", q.size());
      end
      for (int i = 0; i < 4; i++) begin
         got = (i < q.size()) ? q[i] : '0;
         exp = '{d: mk(16'(1 + 8 * i)), t: 1'b0, c: 4'd8};
         tests++;
         if (got !== exp) begin
            fails++;
            $display("FAIL stream_ph%0d got %h/%b/%0d want %h/%b/%0d",
                     i, got.d, got.t, got.c, exp.d, exp.t, exp.c);
         end
      end
   endtask

   task automatic test_backpressure();
      int st;
      int tot = 0;
      rec_t got;
      rec_t exp [3];
      do_reset();
      q.delete();
      ready_out = 1'b0;
      for (int n = 0; n < 16; n++) begin
         push(16'h0101 + 16'(n), 1'b0, st);
         tot += st;
      end
      tests++;
      if (tot !== 0) begin
         fails++;
         $display("FAIL bp_fill_stalls got %0d want 0", tot);
      end
      for (int c = 0; c < 4; c++) begin
         tests++;
         if (valid_out !== 1'b1 || data_out !== mk(16'h0101)
             || ready_in !== 1'b0) begin
            fails++;
            $display("FAIL bp_hold c%0d got v=%b d=%h r=%b want v=1 d=%h r=0",
                     c, valid_out, data_out, ready_in, mk(16'h0101));
         end
         tick(1);
      end
      ready_out = 1'b1;
      tot = 0;
      for (int n = 0; n < 8; n++) begin
         push(16'h0111 + 16'(n), 1'b0, st);
         tot += st;
      end
      tick(1);
      tests++;
      if (tot !== 1) begin
         fails++;
         $display("FAIL bp_release_stalls got %0d want 1", tot);
      end
      tests++;
      if (q.size() !== 3) begin
         fails++;
         $display("FAIL bp_n got %0d want 3", q.size());
      end
      exp[0] = '{d: mk(16'h0101), t: 1'b0, c: 4'd8};
      exp[1] = '{d: mk(16'h0109), t: 1'b0, c: 4'd8};
      exp[2] = '{d: mk(16'h0111), t: 1'b0, c: 4'd8};
      for (int i = 0; i < 3; i++) begin
         got = (i < q.size()) ? q[i] : '0;
         tests++;
         if (got !== exp[i]) begin
            fails++;
            $display("FAIL bp_ph%0d got %h/%b/%0d want %h/%b/%0d",
                     i, got.d, got.t, got.c, exp[i].d, exp[i].t, exp[i].c);
         end
      end
   endtask

   task automatic test_flush();
      int st;
      int tot = 0;
      rec_t got;
      rec_t exp [2];
      do_reset();
      q.delete();
      ready_out = 1'b1;
      push(16'h000A, 1'b0, st);
      tot += st;
      push(16'h000B, 1'b0, st);
      tot += st;
      push(16'h000C, 1'b0, st);
      tot += st;
      for (int n = 0; n < 8; n++) begin
         push(16'h000D + 16'(n), n == 0, st);
         tot += st;
      end
      tick(1);
      tests++;
      if (tot !== 0) begin
         fails++;
         $display("FAIL flush_stalls got %0d want 0", tot);
      end
      tests++;
      if (q.size() !== 2) begin
         fails++;
         $display("FAIL flush_n got %0d want 2", q.size());
      end
      exp[0] = '{d: {16'h000A, 16'h000B, 16'h000C, 80'h0}, t: 1'b0, c: 4'd3};
      exp[1] = '{d: mk(16'h000D), t: 1'b1, c: 4'd8};
      for (int i = 0; i < 2; i++) begin
         got = (i < q.size()) ? q[i] : '0;
         tests++;
         if (got !== exp[i]) begin
            fails++;
            $display("FAIL flush_ph%0d got %h/%b/%0d want %h/%b/%0d",
                     i, got.d, got.t, got.c, exp[i].d, exp[i].t, exp[i].c);
         end
      end
   endtask

   task automatic test_flush_blocked();
      int st;
      int tot = 0;
      rec_t got;
      rec_t exp [3];
      do_reset();
      q.delete();
      ready_out = 1'b0;
      for (int n = 0; n < 8; n++) begin
         push(16'h0201 + 16'(n), 1'b0, st);
         tot += st;
      end
      push(16'h000A, 1'b0, st);
      tot += st;
      push(16'h000B, 1'b0, st);
      tot += st;
      push(16'h000C, 1'b0, st);
      tot += st;
      valid_in = 1'b1;
      data_in = 16'h000D;
      newframe = 1'b1;
      for (int c = 0; c < 3; c++) begin
         @(negedge clk);
         tests++;
         if (ready_in !== 1'b0) begin
            fails++;
            $display("FAIL fb_block c%0d got %b want 0", c, ready_in);
         end
         tick(1);
      end
      ready_out = 1'b1;
      @(negedge clk);
      tests++;
      if (ready_in !== 1'b1) begin
         fails++;
         $display("FAIL fb_unblock got %b want 1", ready_in);
      end
      tick(1);
      valid_in = 1'b0;
      newframe = 1'b0;
      for (int n = 1; n < 8; n++) begin
         push(16'h000D + 16'(n), 1'b0, st);
         tot += st;
      end
      tick(1);
      tests++;
      if (tot !== 0) begin
         fails++;
         $display("FAIL fb_stalls got %0d want 0", tot);
      end
      tests++;
      if (q.size() !== 3) begin
         fails++;
         $display("FAIL fb_n got %0d want 3", q.size());
      end
      exp[0] = '{d: mk(16'h0201), t: 1'b0, c: 4'd8};
      exp[1] = '{d: {16'h000A, 16'h000B, 16'h000C, 80'h0}, t: 1'b0, c: 4'd3};
      exp[2] = '{d: mk(16'h000D), t: 1'b1, c: 4'd8};
      for (int i = 0; i < 3; i++) begin
         got = (i < q.size()) ? q[i] : '0;
         tests++;
         if (got !== exp[i]) begin
            fails++;
            $display("FAIL fb_ph%0d got %h/%b/%0d want %h/%b/%0d",
                     i, got.d, got.t, got.c, exp[i].d, exp[i].t, exp[i].c);
         end
      end
   endtask

   task automatic test_align_off();
      int st;
      rec_t got;
      rec_t exp;
      do_reset();
      q0.delete();
      ready_out = 1'b1;
      for (int n = 0; n < 8; n++)
         push(16'h0301 + 16'(n), n == 4, st);
      tick(1);
      tests++;
      if (q0.size() !== 1) begin
         fails++;
         $display("FAIL a0_n got %0d want 1", q0.size());
      end
      got = (q0.size() > 0) ? q0[0] : '0;
      exp = '{d: mk(16'h0301), t: 1'b1, c: 4'd8};
      tests++;
      if (got !== exp) begin
         fails++;
         $display("FAIL a0_ph got %h/%b/%0d want %h/%b/%0d",
                  got.d, got.t, got.c, exp.d, exp.t, exp.c);
      end
   endtask

   task automatic test_reset_mid();
      int st;
      rec_t got;
      rec_t exp;
      do_reset();
      q.delete();
      ready_out = 1'b1;
      for (int n = 0; n < 5; n++)
         push(16'h0401 + 16'(n), 1'b0, st);
      rst = 1'b1;
      tick(1);
      tests++;
      if (valid_out !== 1'b0 || count_out !== 4'd0) begin
         fails++;
         $display("FAIL rm_rst got v=%b c=%0d want v=0 c=0",
                  valid_out, count_out);
      end
      rst = 1'b0;
      for (int n = 0; n < 8; n++)
         push(16'h0501 + 16'(n), 1'b0, st);
      tick(1);
      tests++;
      if (q.size() !== 1) begin
         fails++;
         $display("FAIL rm_n got %0d want 1", q.size());
      end
      got = (q.size() > 0) ? q[0] : '0;
      exp = '{d: mk(16'h0501), t: 1'b0, c: 4'd8};
      tests++;
      if (got !== exp) begin
         fails++;
         $display("FAIL rm_ph got %h/%b/%0d want %h/%b/%0d",
                  got.d, got.t, got.c, exp.d, exp.t, exp.c);
      end
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog expired");
      $fatal(1, "watchdog");
   end

   initial begin
      rst = 1'b1;
      valid_in = 1'b0;
      newframe = 1'b0;
      data_in = '0;
      ready_out = 1'b1;
      test_reset();
      test_stream();
      test_backpressure();
      test_flush();
      test_flush_blocked();
      test_align_off();
      test_reset_mid();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
